// File: rtl/hcsr04_echo_responder.sv
// HC-SR04 sensor-side emulator: accepts a trigger pulse and answers with an
// echo pulse whose width encodes a programmable distance (or the no-target
// timeout width).
module hcsr04_echo_responder #(
    parameter int unsigned TRIG_MIN_CYC    = 500,
    parameter int unsigned BURST_DELAY_CYC = 10000,
    parameter int unsigned CYC_PER_CM      = 2900,
    parameter int unsigned MIN_CM          = 2,
    parameter int unsigned MAX_CM          = 400,
    parameter int unsigned TIMEOUT_CYC     = 1900000,
    parameter int unsigned HOLDOFF_CYC     = 3000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trigger,
    input  logic [8:0] distance_cm,
    input  logic       object_present,
    output logic       echo,
    output logic       busy,
    output logic       meas_done,
    output logic       trig_err
);

    typedef enum logic [2:0] {
        IDLE,
        TRIG_HI,
        BURST,
        ECHO,
        HOLDOFF
    } state_t;

    localparam logic [21:0] TRIG_MIN    = 22'(TRIG_MIN_CYC);
    localparam logic [21:0] BURST_LEN   = 22'(BURST_DELAY_CYC);
    localparam logic [21:0] HOLD_LEN    = 22'(HOLDOFF_CYC);
    localparam logic [20:0] PER_CM      = 21'(CYC_PER_CM);
    localparam logic [20:0] TIMEOUT_LEN = 21'(TIMEOUT_CYC);
    localparam logic [8:0]  MIN_D       = 9'(MIN_CM);
    localparam logic [8:0]  MAX_D       = 9'(MAX_CM);

    state_t      state;
    logic        trig_m;
    logic        trig_s;
    logic        trig_d;
    logic        trig_rise;
    logic        trig_fall;
    logic [21:0] cnt;
    logic [20:0] echo_len;
    logic [8:0]  dist_clamped;
    logic [20:0] echo_len_next;

    assign trig_rise = trig_s & ~trig_d;
    assign trig_fall = ~trig_s & trig_d;

    // Two-flop synchronizer plus a delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            trig_m <= 1'b0;
            trig_s <= 1'b0;
            trig_d <= 1'b0;
        end else begin
            trig_m <= trigger;
            trig_s <= trig_m;
            trig_d <= trig_s;
        end
    end

    // Clamp the distance first, then scale it to an echo width
    always_comb begin
        dist_clamped = distance_cm;
        if (distance_cm < MIN_D) begin
            dist_clamped = MIN_D;
        end else if (distance_cm > MAX_D) begin
            dist_clamped = MAX_D;
        end
        echo_len_next = object_present ? (21'(dist_clamped) * PER_CM) : TIMEOUT_LEN;
    end

    // Protocol FSM with registered outputs; cnt is shared by every timed phase
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            echo_len  <= '0;
            echo      <= 1'b0;
            busy      <= 1'b0;
            meas_done <= 1'b0;
            trig_err  <= 1'b0;
        end else begin
            meas_done <= 1'b0;
            trig_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (trig_rise) begin
                        state <= TRIG_HI;
                        cnt   <= 22'd1;
                        busy  <= 1'b1;
                    end
                end
                TRIG_HI: begin
                    if (trig_fall) begin
                        if (cnt >= TRIG_MIN) begin
                            echo_len <= echo_len_next;
                            cnt      <= BURST_LEN;
                            state    <= BURST;
                        end else begin
                            trig_err <= 1'b1;
                            busy     <= 1'b0;
                            cnt      <= '0;
                            state    <= IDLE;
                        end
                    end else if (cnt < TRIG_MIN) begin
                        cnt <= cnt + 22'd1;
                    end
                end
                BURST: begin
                    // Leave one cycle early so echo rises exactly
                    // BURST_DELAY_CYC cycles after the detected fall
                    if (cnt <= 22'd2) begin
                        state <= ECHO;
                        echo  <= 1'b1;
                        cnt   <= {1'b0, echo_len};
                    end else begin
                        cnt <= cnt - 22'd1;
                    end
                end
                ECHO: begin
                    if (cnt <= 22'd1) begin
                        echo      <= 1'b0;
                        meas_done <= 1'b1;
                        cnt       <= HOLD_LEN;
                        state     <= HOLDOFF;
                    end else begin
                        cnt <= cnt - 22'd1;
                    end
                end
                HOLDOFF: begin
                    if (cnt <= 22'd1) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 22'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    echo  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hcsr04_echo_responder.sv
// Self-checking bench for hcsr04_echo_responder with shortened timing.
module tb_hcsr04_echo_responder;

    localparam int TRIG_MIN = 10;
    localparam int BURST    = 20;
    localparam int PER_CM   = 4;
    localparam int TIMEOUT  = 2000;
    localparam int HOLDOFF  = 50;
    localparam int SYNC_LAT = 2;
    localparam int BUDGET   = 6000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       trigger = 1'b0;
    logic [8:0] distance_cm = '0;
    logic       object_present = 1'b1;
    logic       echo;
    logic       busy;
    logic       meas_done;
    logic       trig_err;

    int passed = 0;
    int total  = 0;

    hcsr04_echo_responder #(
        .TRIG_MIN_CYC    (TRIG_MIN),
        .BURST_DELAY_CYC (BURST),
        .CYC_PER_CM      (PER_CM),
        .MIN_CM          (2),
        .MAX_CM          (400),
        .TIMEOUT_CYC     (TIMEOUT),
        .HOLDOFF_CYC     (HOLDOFF)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .trigger        (trigger),
        .distance_cm    (distance_cm),
        .object_present (object_present),
        .echo           (echo),
        .busy           (busy),
        .meas_done      (meas_done),
        .trig_err       (trig_err)
    );

    always #5 clk = ~clk;

    // Reference: echo width from the distance rules
    function automatic int ref_width(input int d, input bit obj);
        int c;
        if (!obj) return TIMEOUT;
        c = d;
        if (c < 2) c = 2;
        if (c > 400) c = 400;
        return c * PER_CM;
    endfunction

    // Drive one trigger and observe the complete response
    task automatic measure(input int trig_len, input bit retrig, input int d, input bit obj,
                           output int lat, output int width, output int md_cnt,
                           output int hold, output int rises, output bit timeout);
        bit md_seen;
        bit done;
        bit prev_echo;
        repeat (3) @(negedge clk);
        distance_cm    = 9'(d);
        object_present = obj;
        trigger        = 1'b1;
        repeat (trig_len) @(negedge clk);
        trigger = 1'b0;
        lat = -1; width = 0; md_cnt = 0; hold = 0; rises = 0;
        md_seen = 1'b0; done = 1'b0; prev_echo = 1'b0;
        for (int cyc = 1; cyc <= BUDGET; cyc++) begin
            @(negedge clk);
            if (echo && !prev_echo) begin
                rises++;
                if (lat < 0) lat = cyc;
            end
            prev_echo = echo;
            if (echo) width++;
            if (meas_done) begin
                md_cnt++;
                md_seen = 1'b1;
            end
            if (md_seen && busy) hold++;
            if (md_seen && !busy) begin
                done = 1'b1;
                break;
            end
            if (retrig) begin
                trigger = (cyc >= 4 && cyc < 16) || (echo && width >= 20 && width < 35) ||
                          (md_seen && hold >= 5 && hold < 20);
                if (cyc >= 3) begin
                    distance_cm    = 9'($urandom_range(0, 511));
                    object_present = 1'($urandom_range(0, 1));
                end
            end
        end
        trigger = 1'b0;
        timeout = !done;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        total++; if (echo !== 1'b0) $display("FAIL reset_echo got=%b exp=0", echo); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
        total++; if (meas_done !== 1'b0) $display("FAIL reset_meas_done got=%b exp=0", meas_done); else passed++;
        total++; if (trig_err !== 1'b0) $display("FAIL reset_trig_err got=%b exp=0", trig_err); else passed++;
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_normal();
        int lat, width, md, hold, rises;
        bit to;
        measure(12, 1'b0, 100, 1'b1, lat, width, md, hold, rises, to);
        total++; if (to !== 1'b0) $display("FAIL normal_timeout got=%b exp=0", to); else passed++;
        total++; if (lat !== BURST + SYNC_LAT) $display("FAIL normal_latency got=%0d exp=%0d", lat, BURST + SYNC_LAT); else passed++;
        total++; if (width !== 400) $display("FAIL normal_width got=%0d exp=400", width); else passed++;
        total++; if (md !== 1) $display("FAIL normal_meas_done got=%0d exp=1", md); else passed++;
        total++; if (hold !== HOLDOFF) $display("FAIL normal_holdoff got=%0d exp=%0d", hold, HOLDOFF); else passed++;
        total++; if (rises !== 1) $display("FAIL normal_rises got=%0d exp=1", rises); else passed++;
    endtask

    task automatic test_short_trigger();
        int err_cnt, echo_cnt;
        bit busy_seen;
        repeat (3) @(negedge clk);
        trigger = 1'b1;
        repeat (5) @(negedge clk);
        busy_seen = busy;
        trigger = 1'b0;
        err_cnt = 0; echo_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (trig_err) err_cnt++;
            if (echo) echo_cnt++;
        end
        total++; if (busy_seen !== 1'b1) $display("FAIL short_busy_during got=%b exp=1", busy_seen); else passed++;
        total++; if (err_cnt !== 1) $display("FAIL short_trig_err got=%0d exp=1", err_cnt); else passed++;
        total++; if (echo_cnt !== 0) $display("FAIL short_echo got=%0d exp=0", echo_cnt); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL short_busy_after got=%b exp=0", busy); else passed++;
    endtask

    task automatic test_clamp_and_timeout();
        int lat, width, md, hold, rises;
        bit to;
        measure(10, 1'b0, 0, 1'b1, lat, width, md, hold, rises, to);
        total++; if (width !== 8) $display("FAIL clamp_low_width got=%0d exp=8", width); else passed++;
        measure(14, 1'b0, 450, 1'b1, lat, width, md, hold, rises, to);
        total++; if (width !== 1600) $display("FAIL clamp_high_width got=%0d exp=1600", width); else passed++;
        measure(11, 1'b0, 511, 1'b1, lat, width, md, hold, rises, to);
        total++; if (width !== 1600) $display("FAIL clamp_511_width got=%0d exp=1600", width); else passed++;
        measure(12, 1'b0, 100, 1'b0, lat, width, md, hold, rises, to);
        total++; if (width !== TIMEOUT) $display("FAIL no_target_width got=%0d exp=%0d", width, TIMEOUT); else passed++;
        total++; if (md !== 1) $display("FAIL no_target_meas_done got=%0d exp=1", md); else passed++;
    endtask

    task automatic test_retrigger();
        int lat, width, md, hold, rises;
        bit to;
        measure(12, 1'b1, 60, 1'b1, lat, width, md, hold, rises, to);
        total++; if (to !== 1'b0) $display("FAIL retrig_timeout got=%b exp=0", to); else passed++;
        total++; if (width !== 240) $display("FAIL retrig_width got=%0d exp=240", width); else passed++;
        total++; if (rises !== 1) $display("FAIL retrig_rises got=%0d exp=1", rises); else passed++;
        total++; if (md !== 1) $display("FAIL retrig_meas_done got=%0d exp=1", md); else passed++;
        repeat (10) @(negedge clk);
        total++; if (echo !== 1'b0 || busy !== 1'b0) $display("FAIL retrig_idle_after got=%b%b exp=00", echo, busy); else passed++;
        measure(13, 1'b0, 25, 1'b1, lat, width, md, hold, rises, to);
        total++; if (width !== 100) $display("FAIL retrig_next_width got=%0d exp=100", width); else passed++;
    endtask

    task automatic test_held_trigger();
        int echo_cnt, rises, wait_cyc;
        bit prev;
        repeat (3) @(negedge clk);
        distance_cm = 9'd10;
        object_present = 1'b1;
        trigger = 1'b1;
        echo_cnt = 0;
        repeat (300) begin
            @(negedge clk);
            if (echo) echo_cnt++;
        end
        total++; if (echo_cnt !== 0) $display("FAIL held_echo got=%0d exp=0", echo_cnt); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL held_busy got=%b exp=1", busy); else passed++;
        trigger = 1'b0;
        rises = 0; prev = 1'b0; wait_cyc = 0; echo_cnt = 0;
        while (wait_cyc < BUDGET) begin
            @(negedge clk);
            wait_cyc++;
            if (echo && !prev) rises++;
            if (echo) echo_cnt++;
            prev = echo;
            if (!busy) break;
        end
        total++; if (busy !== 1'b0) $display("FAIL held_release_busy got=%b exp=0", busy); else passed++;
        total++; if (rises !== 1 || echo_cnt !== 40) $display("FAIL held_release_echo got=%0d/%0d exp=1/40", rises, echo_cnt); else passed++;
    endtask

    task automatic test_reset_mid_echo();
        int lat, width, md, hold, rises, n;
        bit to;
        repeat (3) @(negedge clk);
        distance_cm = 9'd200;
        object_present = 1'b1;
        trigger = 1'b1;
        repeat (12) @(negedge clk);
        trigger = 1'b0;
        n = 0;
        while (!echo && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++; if (echo !== 1'b1) $display("FAIL rst_mid_echo_start got=%b exp=1", echo); else passed++;
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++; if (echo !== 1'b0 || busy !== 1'b0) $display("FAIL rst_mid_echo got=%b%b exp=00", echo, busy); else passed++;
        rst = 1'b0;
        measure(12, 1'b0, 77, 1'b1, lat, width, md, hold, rises, to);
        total++; if (width !== 308 || lat !== BURST + SYNC_LAT) $display("FAIL rst_after_echo got=%0d,%0d exp=308,%0d", width, lat, BURST + SYNC_LAT); else passed++;
    endtask

    task automatic test_random();
        int lat, width, md, hold, rises, d, tl, expw;
        bit obj, to;
        for (int i = 0; i < 8; i++) begin
            d   = int'($urandom_range(0, 511));
            obj = ($urandom_range(0, 3) != 0);
            tl  = int'($urandom_range(TRIG_MIN, TRIG_MIN + 15));
            expw = ref_width(d, obj);
            measure(tl, 1'($urandom_range(0, 1)), d, obj, lat, width, md, hold, rises, to);
            total++;
            if (to !== 1'b0 || width !== expw || lat !== BURST + SYNC_LAT || md !== 1 ||
                hold !== HOLDOFF || rises !== 1)
                $display("FAIL random_%0d d=%0d obj=%0d got w=%0d lat=%0d md=%0d hold=%0d rises=%0d to=%0d exp w=%0d lat=%0d",
                         i, d, obj, width, lat, md, hold, rises, to, expw, BURST + SYNC_LAT);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_short_trigger();
        test_clamp_and_timeout();
        test_retrigger();
        test_held_trigger();
        test_reset_mid_echo();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
